// File: rtl/int_controller.sv
// Machine-level interrupt source block: edge-detected external lines plus an optional
// 64-bit mtime/mtimecmp timer (built when INTCTL_TIMER_EN is defined), one eip request.
module int_controller #(
  parameter int NSRC      = 4,
  parameter int TIMER_DIV = 1,
  parameter int HOLDOFF   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] irq_src,
  output logic            eip,
  output logic            eip_istimer,
  input  logic            eip_reply
);

  localparam logic [4:0] TIMER_CODE = 5'd31;
  localparam int CW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  // Handshake: eip rises with eip_istimer valid and both stay frozen until a
  // one-cycle eip_reply is seen in ASSERT; replies in any other state are dropped.
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;

  state_t          state, state_n;
  logic            eip_n, ist_q, ist_n;
  logic [4:0]      sel, sel_n, claim, claim_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            reply_hit;

  logic [NSRC-1:0] irq_q, pend, en_ext, edge_det, w1c_ext, clr_ext, act;
  logic            tpend, en_t;
  logic            win_valid, win_timer;
  logic [4:0]      win_code;

  logic            unused_d;
  assign unused_d = ^d;

  assign edge_det  = irq_src & ~irq_q;
  assign w1c_ext   = (we && a == 3'd4) ? d[NSRC-1:0] : '0;
  assign reply_hit = (state == S_ASSERT) && eip_reply;
  assign act       = pend & en_ext;

  always_comb begin
    clr_ext = '0;
    for (int i = 0; i < NSRC; i++)
      if (reply_hit && sel == 5'(i + 1)) clr_ext[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q  <= '0;
      pend   <= '0;
      en_ext <= '0;
    end else begin
      irq_q <= irq_src;
      pend  <= (pend & ~(w1c_ext | clr_ext)) | edge_det;
      if (we && a == 3'd5) en_ext <= d[NSRC-1:0];
    end
  end

`ifdef INTCTL_TIMER_EN
  localparam int PSW = (TIMER_DIV < 2) ? 1 : $clog2(TIMER_DIV);

  logic [63:0]    mtime, mtimecmp;
  logic [PSW-1:0] ps;
  logic           armed, tick, tset, wr_lo, wr_hi, wr_cmp;

  assign tick   = (ps == PSW'(TIMER_DIV - 1));
  assign wr_lo  = we && a == 3'd0;
  assign wr_hi  = we && a == 3'd1;
  assign wr_cmp = we && (a == 3'd2 || a == 3'd3);
  assign tset   = armed && (mtime >= mtimecmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps       <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      armed    <= 1'b1;
      tpend    <= 1'b0;
      en_t     <= 1'b0;
    end else begin
      ps <= tick ? '0 : ps + 1'b1;
      // A software write to either half owns mtime for that cycle.
      if (wr_lo) mtime[31:0]  <= d;
      if (wr_hi) mtime[63:32] <= d;
      if (!wr_lo && !wr_hi && tick) mtime <= mtime + 64'd1;
      if (we && a == 3'd2) mtimecmp[31:0]  <= d;
      if (we && a == 3'd3) mtimecmp[63:32] <= d;
      if (wr_cmp)    armed <= 1'b1;
      else if (tset) armed <= 1'b0;
      tpend <= tset | (tpend & ~((we && a == 3'd4 && d[16]) ||
                                 (reply_hit && sel == TIMER_CODE)));
      if (we && a == 3'd5) en_t <= d[16];
    end
  end
`else
  assign tpend = 1'b0;
  assign en_t  = 1'b0;
`endif

  // Descending scan so the lowest enabled external index ends up selected.
  always_comb begin
    win_valid = 1'b0;
    win_timer = 1'b0;
    win_code  = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (act[i]) begin
        win_valid = 1'b1;
        win_code  = 5'(i + 1);
      end
    if (!win_valid && tpend && en_t) begin
      win_valid = 1'b1;
      win_timer = 1'b1;
      win_code  = TIMER_CODE;
    end
  end

  always_comb begin
    state_n = state;
    eip_n   = eip;
    ist_n   = ist_q;
    sel_n   = sel;
    cnt_n   = cnt;
    claim_n = claim;
    case (state)
      S_IDLE: if (win_valid) begin
        sel_n   = win_code;
        eip_n   = 1'b1;
        ist_n   = win_timer;
        state_n = S_ASSERT;
      end
      S_ASSERT: if (eip_reply) begin
        eip_n   = 1'b0;
        ist_n   = 1'b0;
        claim_n = sel;
        cnt_n   = CW'(HOLDOFF);
        state_n = S_HOLD;
      end
      S_HOLD: begin
        cnt_n = (cnt == '0) ? '0 : cnt - 1'b1;
        if (cnt <= CW'(1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      eip   <= 1'b0;
      ist_q <= 1'b0;
      sel   <= '0;
      cnt   <= '0;
      claim <= '0;
    end else begin
      state <= state_n;
      eip   <= eip_n;
      ist_q <= ist_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      claim <= claim_n;
    end
  end

  assign eip_istimer = ist_q;

  always_comb begin
    spo = '0;
    case (a)
`ifdef INTCTL_TIMER_EN
      3'd0: spo = mtime[31:0];
      3'd1: spo = mtime[63:32];
      3'd2: spo = mtimecmp[31:0];
      3'd3: spo = mtimecmp[63:32];
`endif
      3'd4: begin
        spo[NSRC-1:0] = pend;
        spo[16]       = tpend;
      end
      3'd5: begin
        spo[NSRC-1:0] = en_ext;
        spo[16]       = en_t;
      end
      3'd6: spo[4:0] = claim;
      default: spo = '0;
    endcase
  end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus randomized external bursts checked
// against a delivery-order model; timer scenarios only when INTCTL_TIMER_EN is defined.
module tb_int_controller;

  localparam int NSRC    = 4;
  localparam int HOLDOFF = 4;
`ifdef INTCTL_TIMER_EN
  localparam bit TIMER_BUILD = 1'b1;
`else
  localparam bit TIMER_BUILD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      a = '0;
  logic [31:0]     d = '0;
  logic            we = 1'b0;
  logic [31:0]     spo;
  logic [NSRC-1:0] irq_src = '0;
  logic            eip, eip_istimer;
  logic            eip_reply = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit ist_seen = 1'b0;
  logic [4:0] exp_q[$];

  int_controller #(.NSRC(NSRC), .TIMER_DIV(1), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
    .irq_src(irq_src), .eip(eip), .eip_istimer(eip_istimer), .eip_reply(eip_reply)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eip_istimer === 1'b1) ist_seen = 1'b1;

  // driver tasks: entered and left at a falling edge
  task automatic wr(input logic [2:0] idx, input logic [31:0] val);
    a = idx; d = val; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_now(input logic [2:0] idx, output logic [31:0] val);
    a = idx;
    #1 val = spo;
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    irq_src = m;
    @(negedge clk);
    irq_src = '0;
  endtask

  task automatic send_reply();
    eip_reply = 1'b1;
    @(negedge clk);
    eip_reply = 1'b0;
  endtask

  task automatic wait_eip(input int max, output int got);
    got = -1;
    for (int i = 0; i < max; i++) begin
      if (eip === 1'b1) begin
        got = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v, e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (eip !== 1'b0 || eip_istimer !== 1'b0) begin
      n_err++;
      $display("FAIL reset_eip: got eip=%b ist=%b expected 0 0", eip, eip_istimer);
    end
    for (int i = 0; i < 8; i++) begin
      e = (TIMER_BUILD && (i == 2 || i == 3)) ? 32'hFFFF_FFFF : 32'h0;
      rd_now(3'(i), v);
      n_cmp++;
      if (v !== e) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, v, e);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] v;
    wr(3'd5, 32'h1);
    pulse(4'b0001);
    n_cmp++;
    if (eip !== 1'b0) begin
      n_err++;
      $display("FAIL single_early: got eip=%b expected 0", eip);
    end
    @(negedge clk);
    n_cmp++;
    if (eip !== 1'b1 || eip_istimer !== 1'b0) begin
      n_err++;
      $display("FAIL single_rise: got eip=%b ist=%b expected 1 0", eip, eip_istimer);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (eip !== 1'b1) begin
        n_err++;
        $display("FAIL single_hold: got eip=%b expected 1", eip);
      end
    end
    send_reply();
    n_cmp++;
    if (eip !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: got eip=%b expected 0", eip);
    end
    rd_now(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL single_pending: got %h expected 0", v);
    end
    rd_now(3'd6, v);
    n_cmp++;
    if (v !== 32'd1) begin
      n_err++;
      $display("FAIL single_claim: got %0d expected 1", v);
    end
    repeat (HOLDOFF + 2) @(negedge clk);
  endtask

  task automatic test_priority();
    logic [31:0] v;
    int c, r;
    wr(3'd5, 32'h6);
    pulse(4'b0110);
    wait_eip(10, c);
    send_reply();
    r = cyc;
    rd_now(3'd6, v);
    n_cmp++;
    if (c < 0 || v !== 32'd2) begin
      n_err++;
      $display("FAIL prio_first: got claim %0d (rise %0d) expected 2", v, c);
    end
    wait_eip(HOLDOFF + 10, c);
    n_cmp++;
    if (c !== r + HOLDOFF + 1) begin
      n_err++;
      $display("FAIL prio_holdoff: got rise %0d expected %0d", c, r + HOLDOFF + 1);
    end
    send_reply();
    rd_now(3'd6, v);
    n_cmp++;
    if (v !== 32'd3) begin
      n_err++;
      $display("FAIL prio_second: got claim %0d expected 3", v);
    end
    repeat (HOLDOFF + 2) @(negedge clk);
  endtask

  task automatic test_w1c_set_wins();
    logic [31:0] v;
    wr(3'd5, 32'h0);
    irq_src = 4'b1000;
    wr(3'd4, 32'h8);
    irq_src = '0;
    rd_now(3'd4, v);
    n_cmp++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL setwins_pending: got %h expected 8", v);
    end
    wr(3'd4, 32'h8);
    rd_now(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL w1c_clear: got %h expected 0", v);
    end
  endtask

  // Model: one burst of edges delivers every enabled pulsed source in ascending
  // index order, first one edge after the pend edge, later ones HOLDOFF+1 after a reply.
  task automatic test_random_external(input int iters);
    logic [NSRC-1:0] m, e;
    logic [31:0] v;
    logic [4:0] code;
    int c, exp_rise, dly;
    for (int it = 0; it < iters; it++) begin
      m = 4'($urandom_range(1, 15));
      e = 4'($urandom_range(0, 15));
      wr(3'd5, 32'(e));
      for (int i = 0; i < NSRC; i++)
        if (m[i] && e[i]) exp_q.push_back(5'(i + 1));
      pulse(m);
      exp_rise = cyc + 1;
      while (exp_q.size() > 0) begin
        code = exp_q.pop_front();
        wait_eip(HOLDOFF + 10, c);
        n_cmp++;
        if (c !== exp_rise || eip_istimer !== 1'b0) begin
          n_err++;
          $display("FAIL rand_rise: got cyc %0d ist %b expected cyc %0d ist 0", c, eip_istimer, exp_rise);
          if (c < 0) begin
            exp_q.delete();
            break;
          end
        end
        dly = $urandom_range(0, 3);
        repeat (dly) begin
          @(negedge clk);
          n_cmp++;
          if (eip !== 1'b1) begin
            n_err++;
            $display("FAIL rand_stable: got eip=%b expected 1", eip);
          end
        end
        send_reply();
        exp_rise = cyc + HOLDOFF + 1;
        rd_now(3'd6, v);
        n_cmp++;
        if (v !== 32'(code) || eip !== 1'b0) begin
          n_err++;
          $display("FAIL rand_claim: got claim %0d eip %b expected %0d 0", v, eip, code);
        end
      end
      repeat (HOLDOFF + 3) @(negedge clk);
      rd_now(3'd4, v);
      n_cmp++;
      if (v !== 32'(m & ~e) || eip !== 1'b0) begin
        n_err++;
        $display("FAIL rand_pending: got %h eip %b expected %h 0", v, eip, m & ~e);
      end
      wr(3'd4, 32'hFFFF_FFFF);
    end
  endtask

`ifdef INTCTL_TIMER_EN
  task automatic test_mtime_wrap();
    logic [31:0] lo, hi;
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'h0);
    repeat (2) @(negedge clk);
    rd_now(3'd1, hi);
    rd_now(3'd0, lo);
    n_cmp++;
    if (hi !== 32'd1 || lo !== 32'd1) begin
      n_err++;
      $display("FAIL mtime_carry: got %h_%h expected 00000001_00000001", hi, lo);
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    int c;
    bit fired;
    wr(3'd5, 32'h1_0000);
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'd100);
    wait_eip(300, c);
    rd_now(3'd0, v);
    n_cmp++;
    if (c < 0 || eip_istimer !== 1'b1 || v !== 32'd102) begin
      n_err++;
      $display("FAIL timer_fire: got rise %0d ist %b mtime %0d expected ist 1 mtime 102", c, eip_istimer, v);
    end
    send_reply();
    rd_now(3'd6, v);
    n_cmp++;
    if (v !== 32'd31 || eip !== 1'b0) begin
      n_err++;
      $display("FAIL timer_claim: got claim %0d eip %b expected 31 0", v, eip);
    end
    rd_now(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL timer_pending: got %h expected 0", v);
    end
    fired = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (eip === 1'b1) fired = 1'b1;
    end
    n_cmp++;
    if (fired !== 1'b0) begin
      n_err++;
      $display("FAIL timer_refire: got eip rise %b expected 0", fired);
    end
    wr(3'd2, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (eip !== 1'b0) begin
      n_err++;
      $display("FAIL timer_rearm_early: got eip=%b expected 0", eip);
    end
    @(negedge clk);
    n_cmp++;
    if (eip !== 1'b1 || eip_istimer !== 1'b1) begin
      n_err++;
      $display("FAIL timer_rearm: got eip=%b ist=%b expected 1 1", eip, eip_istimer);
    end
    send_reply();
    wr(3'd5, 32'h0);
    repeat (HOLDOFF + 2) @(negedge clk);
  endtask
`else
  task automatic test_no_timer();
    logic [31:0] v;
    wr(3'd2, 32'h0);
    wr(3'd0, 32'h5);
    for (int i = 0; i < 4; i++) begin
      rd_now(3'(i), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_err++;
        $display("FAIL notimer_reg%0d: got %h expected 0", i, v);
      end
    end
    wr(3'd5, 32'hFFFF_FFFF);
    rd_now(3'd5, v);
    n_cmp++;
    if (v !== 32'hF) begin
      n_err++;
      $display("FAIL notimer_enable: got %h expected f", v);
    end
    wr(3'd5, 32'h0);
  endtask
`endif

  task automatic test_reset_mid_assert();
    int c;
    wr(3'd5, 32'h8);
    pulse(4'b1000);
    wait_eip(10, c);
    wr(3'd5, 32'h0);
    wr(3'd4, 32'h8);
    n_cmp++;
    if (c < 0 || eip !== 1'b1) begin
      n_err++;
      $display("FAIL midassert_hold: got eip=%b expected 1", eip);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (eip !== 1'b0 || eip_istimer !== 1'b0) begin
      n_err++;
      $display("FAIL midassert_reset: got eip=%b ist=%b expected 0 0", eip, eip_istimer);
    end
    test_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_w1c_set_wins();
    test_random_external(20);
`ifdef INTCTL_TIMER_EN
    test_mtime_wrap();
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_mid_assert();
    if (!TIMER_BUILD) begin
      n_cmp++;
      if (ist_seen !== 1'b0) begin
        n_err++;
        $display("FAIL notimer_istimer: got ist seen %b expected 0", ist_seen);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
